// File: rtl/ps2_keymap_decoder_if.sv
// ps2_keymap_decoder_if: scan-byte input and decoded key/volume event bundle.
interface ps2_keymap_decoder_if #(parameter int KEY_CNT = 8);
  logic [7:0]                 ps2_data_i;
  logic                       ps2_data_val_i;
  logic [$clog2(KEY_CNT)-1:0] key_num_o;
  logic                       key_press_o;
  logic                       key_evt_val_o;
  logic [KEY_CNT-1:0]         key_held_o;
  logic                       vol_cntrl_o;
  logic                       vol_cntrl_val_o;
  logic                       seq_err_o;
  modport master (
    output ps2_data_i, ps2_data_val_i,
    input  key_num_o, key_press_o, key_evt_val_o, key_held_o,
           vol_cntrl_o, vol_cntrl_val_o, seq_err_o
  );
  modport slave (
    input  ps2_data_i, ps2_data_val_i,
    output key_num_o, key_press_o, key_evt_val_o, key_held_o,
           vol_cntrl_o, vol_cntrl_val_o, seq_err_o
  );
endinterface

// File: rtl/ps2_keymap_decoder.sv
// ps2_keymap_decoder: PS/2 scan-code prefix FSM, key table lookup, held bitmap,
// typematic filtering and registered key/volume events.
module ps2_keymap_decoder #(
  parameter int           KEY_CNT     = 8,
  parameter logic [255:0] KEY_CODES   = {192'h0, 64'h3E3D362E25261E16},
  parameter bit           REPEAT_EN   = 1'b0,
  parameter int           TIMEOUT_CYC = 1_000_000
) (
  input logic clk_i,
  input logic rst_n_i,
  ps2_keymap_decoder_if.slave bus
);
  localparam int KW = $clog2(KEY_CNT);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  logic [2:0]         r_state, w_next;
  logic [2:0]         r_skip;
  logic [TW-1:0]      r_cnt;
  logic [KW-1:0]      r_key_num;
  logic               r_key_press, r_key_evt;
  logic [KEY_CNT-1:0] r_held;
  logic               r_vol, r_vol_val, r_err;
  logic               r_vup, r_vdn;

  logic [7:0]    w_byte;
  logic          w_val, w_e0, w_e1, w_f0, w_pfx, w_ignore;
  logic          w_hit;
  logic [KW-1:0] w_idx;
  logic          w_make, w_brk, w_xmake, w_xbrk, w_perr, w_tout;
  logic          w_press_evt, w_rel_evt, w_vup, w_vdn, w_vol_evt;

  assign w_byte   = bus.ps2_data_i;
  assign w_val    = bus.ps2_data_val_i;
  assign w_e0     = w_byte == 8'hE0;
  assign w_e1     = w_byte == 8'hE1;
  assign w_f0     = w_byte == 8'hF0;
  assign w_pfx    = w_e0 | w_e1 | w_f0;
  assign w_ignore = w_byte == 8'hAA || w_byte == 8'hFA || w_byte == 8'hFE ||
                    w_byte == 8'hEE || w_byte == 8'h00 || w_byte == 8'hFF;

  // Scan downward so the lowest matching entry is the one left standing
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = KEY_CNT - 1; k >= 0; k--)
      if (KEY_CODES[8*k +: 8] == w_byte) begin
        w_hit = 1'b1;
        w_idx = KW'(k);
      end
  end

  assign w_make  = w_val && r_state == S_IDLE && !w_pfx && !w_ignore;
  assign w_brk   = w_val && r_state == S_BRK && !w_pfx;
  assign w_xmake = w_val && r_state == S_EXT && !w_pfx;
  assign w_xbrk  = w_val && r_state == S_EXT_BRK && !w_pfx;
  assign w_perr  = w_val && ((r_state == S_EXT && (w_e0 || w_e1)) ||
                   ((r_state == S_BRK || r_state == S_EXT_BRK) && w_pfx));
  // Fires on the idle clock that would bring the count up to TIMEOUT_CYC
  assign w_tout  = !w_val && r_state != S_IDLE && r_cnt == TW'(TIMEOUT_CYC - 1);

  assign w_press_evt = w_make && w_hit && (!r_held[w_idx] || REPEAT_EN);
  assign w_rel_evt   = w_brk && w_hit && r_held[w_idx];
  assign w_vup       = w_xmake && w_byte == 8'h32;
  assign w_vdn       = w_xmake && w_byte == 8'h21;
  assign w_vol_evt   = (w_vup && (!r_vup || REPEAT_EN)) || (w_vdn && (!r_vdn || REPEAT_EN));

  always_comb begin
    w_next = r_state;
    if (w_val)
      case (r_state)
        S_IDLE:  w_next = w_e0 ? S_EXT : w_f0 ? S_BRK : w_e1 ? S_PAUSE : S_IDLE;
        S_EXT:   w_next = w_f0 ? S_EXT_BRK : S_IDLE;
        S_PAUSE: w_next = r_skip == 3'd1 ? S_IDLE : S_PAUSE;
        default: w_next = S_IDLE;
      endcase
    else if (w_tout)
      w_next = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_skip      <= '0;
      r_cnt       <= '0;
      r_key_num   <= '0;
      r_key_press <= 1'b0;
      r_key_evt   <= 1'b0;
      r_held      <= '0;
      r_vol       <= 1'b0;
      r_vol_val   <= 1'b0;
      r_err       <= 1'b0;
      r_vup       <= 1'b0;
      r_vdn       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_val || w_tout) ? '0 : (r_state != S_IDLE) ? r_cnt + 1'b1 : r_cnt;
      r_err     <= w_perr || w_tout;
      r_key_evt <= w_press_evt || w_rel_evt;
      r_vol_val <= w_vol_evt;
      if (w_val && r_state == S_IDLE && w_e1)
        r_skip <= 3'd7;
      else if (w_val && r_state == S_PAUSE)
        r_skip <= r_skip - 1'b1;
      if (w_press_evt || w_rel_evt) begin
        r_key_num   <= w_idx;
        r_key_press <= w_press_evt;
      end
      if (w_make && w_hit)
        r_held[w_idx] <= 1'b1;
      if (w_rel_evt)
        r_held[w_idx] <= 1'b0;
      if (w_vol_evt)
        r_vol <= w_vup;
      if (w_vup)
        r_vup <= 1'b1;
      else if (w_xbrk && w_byte == 8'h32)
        r_vup <= 1'b0;
      if (w_vdn)
        r_vdn <= 1'b1;
      else if (w_xbrk && w_byte == 8'h21)
        r_vdn <= 1'b0;
    end
  end

  assign bus.key_num_o       = r_key_num;
  assign bus.key_press_o     = r_key_press;
  assign bus.key_evt_val_o   = r_key_evt;
  assign bus.key_held_o      = r_held;
  assign bus.vol_cntrl_o     = r_vol;
  assign bus.vol_cntrl_val_o = r_vol_val;
  assign bus.seq_err_o       = r_err;
endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// tb_ps2_keymap_decoder: two decoders (repeat off / repeat on) fed the same
// byte stream and checked every cycle against a sequence-level model.
module tb_ps2_keymap_decoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d;
  logic       v;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  ps2_keymap_decoder_if #(.KEY_CNT(8)) b0 ();
  ps2_keymap_decoder_if #(.KEY_CNT(8)) b1 ();
  assign b0.ps2_data_i = d;
  assign b0.ps2_data_val_i = v;
  assign b1.ps2_data_i = d;
  assign b1.ps2_data_val_i = v;

  ps2_keymap_decoder #(.KEY_CNT(8), .REPEAT_EN(1'b0), .TIMEOUT_CYC(16)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b0));
  ps2_keymap_decoder #(.KEY_CNT(8), .REPEAT_EN(1'b1), .TIMEOUT_CYC(16)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b1));

  logic [7:0] tbl [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
  logic [7:0] sp [10] = '{8'hE0, 8'hF0, 8'hE1, 8'h32, 8'h21, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'hEE};

  // Model: pending-prefix flags, remaining Pause bytes, idle clocks since last byte
  bit         m_ext [2], m_brk [2], m_vup [2], m_vdn [2];
  int         m_pause [2], m_idle [2];
  logic [7:0] m_held [2];
  logic [2:0] e_num [2];
  bit         e_press [2], e_kval [2], e_vol [2], e_vval [2], e_err [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ext[m] = 0; m_brk[m] = 0; m_vup[m] = 0; m_vdn[m] = 0;
      m_pause[m] = 0; m_idle[m] = 0; m_held[m] = '0;
      e_num[m] = '0; e_press[m] = 0; e_kval[m] = 0; e_vol[m] = 0; e_vval[m] = 0; e_err[m] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] by, input bit vl);
    for (int m = 0; m < 2; m++) begin
      bit rep;
      int hit;
      rep = (m == 1);
      hit = -1;
      e_kval[m] = 0; e_vval[m] = 0; e_err[m] = 0;
      for (int i = 7; i >= 0; i--) if (tbl[i] == by) hit = i;
      if (vl) begin
        m_idle[m] = 0;
        if (m_pause[m] > 0) m_pause[m]--;
        else if (m_brk[m]) begin
          if (by == 8'hE0 || by == 8'hE1 || by == 8'hF0) e_err[m] = 1;
          else if (m_ext[m]) begin
            if (by == 8'h32) m_vup[m] = 0;
            if (by == 8'h21) m_vdn[m] = 0;
          end else if (hit >= 0 && m_held[m][hit]) begin
            m_held[m][hit] = 0;
            e_kval[m] = 1; e_num[m] = 3'(hit); e_press[m] = 0;
          end
          m_ext[m] = 0; m_brk[m] = 0;
        end else if (m_ext[m]) begin
          if (by == 8'hF0) m_brk[m] = 1;
          else begin
            if (by == 8'hE0 || by == 8'hE1) e_err[m] = 1;
            else if (by == 8'h32) begin
              if (!m_vup[m] || rep) begin e_vval[m] = 1; e_vol[m] = 1; end
              m_vup[m] = 1;
            end else if (by == 8'h21) begin
              if (!m_vdn[m] || rep) begin e_vval[m] = 1; e_vol[m] = 0; end
              m_vdn[m] = 1;
            end
            m_ext[m] = 0;
          end
        end else begin
          if (by == 8'hE0) m_ext[m] = 1;
          else if (by == 8'hF0) m_brk[m] = 1;
          else if (by == 8'hE1) m_pause[m] = 7;
          else if (hit >= 0) begin
            if (!m_held[m][hit] || rep) begin e_kval[m] = 1; e_num[m] = 3'(hit); e_press[m] = 1; end
            m_held[m][hit] = 1;
          end
        end
      end else if (m_ext[m] || m_brk[m] || m_pause[m] > 0) begin
        m_idle[m]++;
        if (m_idle[m] == 16) begin
          e_err[m] = 1; m_ext[m] = 0; m_brk[m] = 0; m_pause[m] = 0; m_idle[m] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
    end
  endtask

  task automatic compare();
    chk("num0", 32'(b0.key_num_o), 32'(e_num[0]));
    chk("press0", 32'(b0.key_press_o), 32'(e_press[0]));
    chk("kval0", 32'(b0.key_evt_val_o), 32'(e_kval[0]));
    chk("held0", 32'(b0.key_held_o), 32'(m_held[0]));
    chk("vol0", 32'(b0.vol_cntrl_o), 32'(e_vol[0]));
    chk("vval0", 32'(b0.vol_cntrl_val_o), 32'(e_vval[0]));
    chk("err0", 32'(b0.seq_err_o), 32'(e_err[0]));
    chk("num1", 32'(b1.key_num_o), 32'(e_num[1]));
    chk("press1", 32'(b1.key_press_o), 32'(e_press[1]));
    chk("kval1", 32'(b1.key_evt_val_o), 32'(e_kval[1]));
    chk("held1", 32'(b1.key_held_o), 32'(m_held[1]));
    chk("vol1", 32'(b1.vol_cntrl_o), 32'(e_vol[1]));
    chk("vval1", 32'(b1.vol_cntrl_val_o), 32'(e_vval[1]));
    chk("err1", 32'(b1.seq_err_o), 32'(e_err[1]));
  endtask

  task automatic step(input logic [7:0] by, input bit vl);
    @(negedge clk);
    compare();
    d = by;
    v = vl;
    model_step(by, vl);
  endtask

  task automatic settle();
    step(8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare();
    v = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    d = 8'h00;
    model_step(8'h00, 1'b0);
  endtask

  function automatic logic [7:0] rnd_byte();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 45) return tbl[$urandom_range(0, 7)];
    if (r < 90) return sp[$urandom_range(0, 9)];
    return 8'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0;
    d = 8'h00;
    v = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    rst_n = 1'b1;

    step(8'h1E, 1); settle();
    chk("t1_kval", 32'(b0.key_evt_val_o), 1);
    chk("t1_num", 32'(b0.key_num_o), 1);
    chk("t1_press", 32'(b0.key_press_o), 1);
    chk("t1_held", 32'(b0.key_held_o), 32'h02);
    step(8'hF0, 1); step(8'h1E, 1); settle();
    chk("t1_rel", 32'(b0.key_press_o), 0);
    chk("t1_relv", 32'(b0.key_evt_val_o), 1);
    chk("t1_held0", 32'(b0.key_held_o), 0);

    step(8'h16, 1); settle();
    chk("t2_first0", 32'(b0.key_evt_val_o), 1);
    step(8'h16, 1); settle();
    chk("t2_rep0", 32'(b0.key_evt_val_o), 0);
    chk("t2_rep1", 32'(b1.key_evt_val_o), 1);
    step(8'h16, 1); step(8'h16, 1); step(8'hF0, 1); step(8'h16, 1);

    step(8'hE0, 1); step(8'h32, 1); settle();
    chk("t3_up", 32'(b0.vol_cntrl_o), 1);
    chk("t3_upv", 32'(b0.vol_cntrl_val_o), 1);
    step(8'hE0, 1); step(8'hF0, 1); step(8'h32, 1); settle();
    chk("t3_brkv", 32'(b0.vol_cntrl_val_o), 0);
    step(8'hE0, 1); step(8'h21, 1); settle();
    chk("t3_dn", 32'(b0.vol_cntrl_o), 0);
    chk("t3_dnv", 32'(b0.vol_cntrl_val_o), 1);
    step(8'hE0, 1); step(8'hF0, 1); step(8'h21, 1);

    step(8'hE1, 1); step(8'h14, 1); step(8'h77, 1); step(8'hE1, 1);
    step(8'hF0, 1); step(8'h14, 1); step(8'hF0, 1); step(8'h77, 1);
    step(8'h26, 1); settle();
    chk("t4_kval", 32'(b0.key_evt_val_o), 1);
    chk("t4_num", 32'(b0.key_num_o), 2);
    step(8'hF0, 1); step(8'h26, 1);

    step(8'hF0, 1);
    repeat (16) step(8'h00, 0);
    settle();
    chk("t5_err", 32'(b0.seq_err_o), 1);
    step(8'h25, 1); settle();
    chk("t5_num", 32'(b0.key_num_o), 3);
    chk("t5_press", 32'(b0.key_press_o), 1);

    step(8'h1E, 1); step(8'h26, 1); step(8'hE0, 1);
    do_reset();
    step(8'h32, 1); settle();
    chk("t6_vval", 32'(b0.vol_cntrl_val_o), 0);
    chk("t6_held", 32'(b0.key_held_o), 0);

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      if ($urandom_range(0, 99) < 60) step(rnd_byte(), 1);
      else step(8'h00, 0);
      if ($urandom_range(0, 149) == 0) repeat (18) step(8'h00, 0);
    end
    settle();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
